// File: rtl/sync_to_oneof2_tx.sv
// Clocked-to-dual-rail (1-of-2, four-phase RTZ) transmitter with enable-style ack.
// Define SYNC_TX_FIFO_EN to replace the single holding register with a 2**FIFO_AW-entry FIFO.
module sync_to_oneof2_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [2*WIDTH-1:0]   L,
  input  logic                 Le,
  output logic                 busy,
  output logic [15:0]          tx_count
);

  typedef enum logic [1:0] {IDLE, DATA, RTZ} state_e;

  state_e                 state_q;
  logic [2*WIDTH-1:0]     rails_q;
  logic [15:0]            txCount_q;
  logic [SYNC_STAGES-1:0] leSync_q;
  logic                   leS;
  logic                   push;
  logic                   pop;
  logic                   wordAvail;
  logic [WIDTH-1:0]       headData;

  function automatic logic [2*WIDTH-1:0] encodeRails(input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  // Le is fully asynchronous; only the last synchronizer stage is ever used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leSync_q <= '0;
    end else begin
      leSync_q <= {leSync_q[SYNC_STAGES-2:0], Le};
    end
  end

  assign leS  = leSync_q[SYNC_STAGES-1];
  assign push = in_valid && in_ready;
  assign pop  = (state_q == IDLE) && wordAvail && leS;

`ifdef SYNC_TX_FIFO_EN
  localparam int                 DEPTH      = 2**FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW+1)'(1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_q;
  logic [FIFO_AW-1:0] rdPtr_q;
  logic [FIFO_AW:0]   count_q;
  logic [FIFO_AW:0]   count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= in_data;
  end

  assign in_ready  = (count_q != FULL_COUNT);
  assign wordAvail = (count_q != '0);
  assign headData  = mem_q[rdPtr_q];
`else
  logic             holdValid_q;
  logic [WIDTH-1:0] holdData_q;

  // in_ready is low while full, so push and pop never coincide here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
    end else if (push) begin
      holdValid_q <= 1'b1;
      holdData_q  <= in_data;
    end else if (pop) begin
      holdValid_q <= 1'b0;
    end
  end

  assign in_ready  = ~holdValid_q;
  assign wordAvail = holdValid_q;
  assign headData  = holdData_q;
`endif

  // Rails change only on IDLE->DATA and DATA->RTZ, always from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rails_q   <= '0;
      txCount_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            rails_q <= encodeRails(headData);
            state_q <= DATA;
          end
        end
        DATA: begin
          if (!leS) begin
            rails_q   <= '0;
            txCount_q <= txCount_q + 16'd1;
            state_q   <= RTZ;
          end
        end
        RTZ: begin
          if (leS) state_q <= IDLE;
        end
        default: begin
          rails_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign L        = rails_q;
  assign tx_count = txCount_q;
  assign busy     = (state_q != IDLE) || wordAvail;

endmodule

// File: tb/tb_sync_to_oneof2_tx.sv
// Scoreboard bench for sync_to_oneof2_tx: stimulus queues expected rail words,
// a monitor compares each token as it appears and checks rail hygiene every cycle.
module tb_sync_to_oneof2_tx;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
`ifdef SYNC_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        Le = 1'b0;
  logic        in_ready;
  logic [15:0] L;
  logic        busy;
  logic [15:0] tx_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] expQ [$];
  logic [15:0] prevL = 16'h0000;

  sync_to_oneof2_tx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .FIFO_AW(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .L(L), .Le(Le), .busy(busy), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // Rail pair i carries bit i as {bit1, bit0} at L[2i+1:2i].
  function automatic logic [15:0] railsOf(input logic [7:0] w);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 400; t++) begin
      if (in_ready) begin
        @(posedge clk);
        expQ.push_back(railsOf(w));
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    total++;
    if (!accepted) begin
      bad++;
      $display("[TB] FAIL pushTimeout word=%h actual=not_accepted expected=accepted", w);
    end
  endtask

  task automatic waitTokenUp(input int bound);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (L != 16'h0000) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("tokenUpWithinBound", {31'd0, seen}, 32'd1);
  endtask

  task automatic waitTokenDown(input int bound);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (L == 16'h0000) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("tokenDownWithinBound", {31'd0, seen}, 32'd1);
  endtask

  task automatic handshake(input int d1, input int d2);
    @(negedge clk);
    Le = 1'b1;
    waitTokenUp(60);
    repeat (d1) @(negedge clk);
    Le = 1'b0;
    waitTokenDown(60);
    repeat (d2) @(negedge clk);
  endtask

  // Monitor: token order against the scoreboard plus one-hot/null rail hygiene.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevL = L;
    end else begin
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (L[2*i+1] && L[2*i]) ok = 1'b0;
        if (L != 16'h0000 && (L[2*i+1] == L[2*i])) ok = 1'b0;
      end
      if (prevL != 16'h0000 && L != 16'h0000 && L != prevL) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("[TB] FAIL railHygiene actual=%h prev=%h", L, prevL);
      end
      if (prevL == 16'h0000 && L != 16'h0000) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpectedToken actual=%h expected=none", L);
        end else begin
          logic [15:0] exp;
          exp = expQ.pop_front();
          if (L !== exp) begin
            bad++;
            $display("[TB] FAIL tokenOrder actual=%h expected=%h", L, exp);
          end
        end
      end
      prevL = L;
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("resetL", {16'd0, L}, 32'd0);
    checkOutput("resetInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetTxCount", {16'd0, tx_count}, 32'd0);

    // Token 0xA5 with Le already high, then measured fall latency.
    Le = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'hA5);
    waitTokenUp(SYNC + 1);
    checkOutput("tokenA5", {16'd0, L}, {16'd0, 16'b1001100101100110});
    @(negedge clk);
    Le = 1'b0;
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    checkOutput("fallHeld", {16'd0, L}, {16'd0, 16'b1001100101100110});
    @(posedge clk);
    @(negedge clk);
    checkOutput("fallLatency", {16'd0, L}, 32'd0);
    checkOutput("txCountOne", {16'd0, tx_count}, 32'd1);
    Le = 1'b1;
    repeat (4) @(negedge clk);
    Le = 1'b0;
    repeat (4) @(negedge clk);

    // Word buffered while Le low, then measured rise latency.
    applyStimulus(8'h3C);
    repeat (3) @(negedge clk);
    checkOutput("idleNoLe", {16'd0, L}, 32'd0);
    checkOutput("busyBuffered", {31'd0, busy}, 32'd1);
    checkOutput("readyWhileBuffered", {31'd0, in_ready}, (DEPTH > 1) ? 32'd1 : 32'd0);
    Le = 1'b1;
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    checkOutput("riseNotYet", {16'd0, L}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("token3C", {16'd0, L}, {16'd0, 16'b0101101010100101});
    Le = 1'b0;
    waitTokenDown(10);
    checkOutput("txCountTwo", {16'd0, tx_count}, 32'd2);

    // Fill the buffer with Le low, then drain in order.
    for (int k = 1; k <= DEPTH; k++) applyStimulus(8'(k));
    @(negedge clk);
    checkOutput("fullNotReady", {31'd0, in_ready}, 32'd0);
    checkOutput("fullNoToken", {16'd0, L}, 32'd0);
    for (int k = 0; k < DEPTH; k++) handshake(1, 1);
    checkOutput("txCountDrained", {16'd0, tx_count}, 32'(2 + DEPTH));

    // Asynchronous reset in the middle of a token.
    applyStimulus(8'h77);
    @(negedge clk);
    Le = 1'b1;
    waitTokenUp(20);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncResetL", {16'd0, L}, 32'd0);
    checkOutput("asyncResetBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncResetTxCount", {16'd0, tx_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expQ.delete();
    checkOutput("postResetReady", {31'd0, in_ready}, 32'd1);
    checkOutput("postResetBusy", {31'd0, busy}, 32'd0);
    applyStimulus(8'h4E);
    waitTokenUp(SYNC + 6);
    Le = 1'b0;
    waitTokenDown(10);
    checkOutput("postResetTxCount", {16'd0, tx_count}, 32'd1);

    // Random producer gaps against a receiver with random Le delays.
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          applyStimulus(8'($urandom));
        end
      end
      begin
        for (int n = 0; n < 1000; n++) handshake($urandom_range(0, 3), $urandom_range(0, 3));
      end
    join
    repeat (4) @(negedge clk);
    checkOutput("randomTxCount", {16'd0, tx_count}, 32'd1001);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
